data_memory_dump: RTL
=====================

# data_memory_dump

Sequential read-out engine for the data memory: the read-side counterpart of the bench preload path that fills data memory word by word. On a start pulse it reads a run of 32-bit words from the data memory port and presents each word with its byte address on a valid/ready stream. It sits beside the MEM stage on the data memory interface and is used for post-run memory inspection and self-checking benches.

## Interface
- `ADDR_W`, 8: data memory byte-address width.
- `DATA_W`, 32: word width.
- `CNT_W`, 7: width of word count; max run is 64 words (256 bytes).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `start_addr` in ADDR_W: first byte address; bits [1:0] are forced to 0 at capture.
- `word_count` in CNT_W: number of words to read; valid values 0..64.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run.
- `mem_address` out ADDR_W: data memory address.
- `mem_enable` out 1: data memory enable; high only in READ.
- `mem_rw` out 1: constant 0 (read).
- `mem_size` out 1: constant 1 (word access).
- `mem_data_out` in DATA_W: combinational read data from data memory.
- `dump_data` out DATA_W: captured word.
- `dump_addr` out ADDR_W: byte address of `dump_data`.
- `dump_valid` out 1: stream valid.
- `dump_ready` in 1: stream ready from consumer.
- `checksum` out DATA_W: running word sum (see Configuration).

## Operation
- States: IDLE, READ, HOLD, DONE.
- IDLE: `start`=1 captures `start_addr & ~3` into the address register and `word_count` into the remaining counter. If `word_count`=0 go to DONE, else go to READ.
- READ: `mem_enable`=1, `mem_address`=address register. At the clock edge, capture `mem_data_out` into `dump_data`, address into `dump_addr`, set `dump_valid`, go to HOLD.
- HOLD: `dump_valid`=1, `dump_data`/`dump_addr` held stable. Transfer occurs on an edge with `dump_valid` & `dump_ready`. On transfer: decrement remaining, advance address by 4 (mod 2^ADDR_W, so 0xFC wraps to 0x00), clear `dump_valid`; go to READ if remaining after decrement > 0, else DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=1, then IDLE.
- `start` outside IDLE is ignored; no queuing.
- `word_count` > 64 is clamped to 64.
- `mem_address` holds its last value outside READ; `mem_enable`=0 there.

## Timing
- Reset (async, any state): state=IDLE, `busy`=0, `done`=0, `dump_valid`=0, `dump_data`=0, `dump_addr`=0, `mem_address`=0, `mem_enable`=0, `checksum`=0. Reset mid-run abandons the run; no `done` pulse.
- Start edge at cycle 0 puts the block in READ during cycle 1, and `dump_valid` rises in cycle 2.
- With `dump_ready` held high, one word is transferred every 2 cycles. An N-word run has `done` high in cycle 2N+1 and `busy` low from cycle 2N+2.
- With `word_count`=0, `done` is high in cycle 1 and no memory access occurs.
- Ready before valid is permitted. Valid never drops without a transfer, except on reset.

## Configuration
- `DUMP_CHECKSUM_EN` defined: `checksum` is cleared on an accepted start. On each stream transfer it is updated to `checksum + dump_data` mod 2^32. It holds its value after DONE until the next start.
- Not defined: `checksum` is tied to 0 and no adder or register is synthesized. All other behaviour is identical.

## Test plan
- Memory preloaded with words 0x11111111, 0x22222222, 0x33333333 at byte addresses 0x00, 0x04, 0x08. Start with `start_addr`=0x00, `word_count`=3, `dump_ready`=1 -> stream (0x00,0x11111111), (0x04,0x22222222), (0x08,0x33333333). `done` is high in cycle 7. With the macro, `checksum`=0x66666666.
- Same run with `dump_ready` low for 5 cycles while word 2 is valid -> `dump_data`=0x22222222 and `dump_addr`=0x04 stay stable throughout. No address advance, and `mem_enable` stays 0 during the stall.
- `start_addr`=0xFA, `word_count`=2 -> addresses 0xF8 then 0xFC. Then `start_addr`=0xFC, `word_count`=2 -> addresses 0xFC then 0x00 (wrap).
- `word_count`=0 -> `done` high in cycle 1, `dump_valid` never asserted, `mem_enable` never asserted.
- Second `start` pulse during a 4-word run -> ignored; exactly 4 words are transferred and one `done` pulse occurs.
- `reset` asserted asynchronously in HOLD of word 2 -> all outputs go to reset values immediately. A subsequent start with `word_count`=1 completes normally.

Source files
------------

// File: rtl/data_memory_dump_if.sv
// Data memory port plus dump stream for data_memory_dump.
// master: the dump engine; slave: the memory and stream consumer side.
interface data_memory_dump_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_enable;
    logic              mem_rw;
    logic              mem_size;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_addr;
    logic              dump_valid;
    logic              dump_ready;

    modport master (
        output mem_address, mem_enable, mem_rw, mem_size,
        input  mem_data_out,
        output dump_data, dump_addr, dump_valid,
        input  dump_ready
    );

    modport slave (
        input  mem_address, mem_enable, mem_rw, mem_size,
        output mem_data_out,
        input  dump_data, dump_addr, dump_valid,
        output dump_ready
    );
endinterface

// File: rtl/data_memory_dump.sv
// data_memory_dump: reads a run of words from data memory and streams each word
// with its byte address over a valid/ready handshake.
// Optional feature macro: DUMP_CHECKSUM_EN (running 32-bit sum of streamed words).
module data_memory_dump #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    data_memory_dump_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRead, StHold, StDone} state_t;

    localparam logic [CNT_W-1:0] MaxCount = {1'b1, {(CNT_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] dump_data_q;
    logic [ADDR_W-1:0] dump_addr_q;
    logic              dump_valid_q;
    logic [CNT_W-1:0]  count_clamped;
    logic              xfer;

    assign count_clamped = (word_count > MaxCount) ? MaxCount : word_count;

    // Next-state, address/count update and transfer decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        xfer        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = start_addr & ~ADDR_W'(3);
                    remaining_d = count_clamped;
                    state_d     = (count_clamped == '0) ? StDone : StRead;
                end
            end
            StRead: state_d = StHold;
            StHold: begin
                if (bus.dump_ready) begin
                    xfer        = 1'b1;
                    remaining_d = remaining_q - CNT_W'(1);
                    addr_d      = addr_q + ADDR_W'(4);  // wraps mod 2^ADDR_W
                    state_d     = (remaining_q == CNT_W'(1)) ? StDone : StRead;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, address, counter and captured stream word registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remaining_q  <= '0;
            mem_addr_q   <= '0;
            dump_data_q  <= '0;
            dump_addr_q  <= '0;
            dump_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            // mem_address only moves when entering READ, so it holds elsewhere.
            if (state_d == StRead) begin
                mem_addr_q <= addr_d;
            end
            if (state_q == StRead) begin
                dump_data_q  <= bus.mem_data_out;
                dump_addr_q  <= addr_q;
                dump_valid_q <= 1'b1;
            end else if (xfer) begin
                dump_valid_q <= 1'b0;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running sum: cleared on accepted start, accumulates each transferred word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (state_q == StIdle && start) begin
            checksum_q <= '0;
        end else if (xfer) begin
            checksum_q <= checksum_q + dump_data_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign bus.mem_address = mem_addr_q;
    assign bus.mem_enable  = (state_q == StRead);
    assign bus.mem_rw      = 1'b0;
    assign bus.mem_size    = 1'b1;
    assign bus.dump_data   = dump_data_q;
    assign bus.dump_addr   = dump_addr_q;
    assign bus.dump_valid  = dump_valid_q;

endmodule
